// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage HI/LO unit running MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Define MUL_ITER_EN for a WIDTH-cycle shift-add multiply instead of the single-cycle array multiply.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [4:0] DIV_CONTROL   = 5'b10000;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10001;
    localparam logic [4:0] MULT_CONTROL  = 5'b10010;
    localparam logic [4:0] MULTU_CONTROL = 5'b10011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10101;
    localparam int         CW            = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [WIDTH-1:0] r_rem, r_quo, r_opb;
    logic             r_sa, r_sb, r_signed, r_is_mul;

    logic             w_is_mul, w_is_div, w_is_signed, w_issue, w_last_iter;
    logic             w_sa, w_sb, w_neg_q, w_neg_r;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_fix_hi, w_fix_lo;
    logic [WIDTH:0]   w_shift, w_trial;
    logic [2*WIDTH-1:0] w_prod_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_is_mul    = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
    assign w_is_div    = (alucontrol == DIV_CONTROL)  || (alucontrol == DIVU_CONTROL);
    assign w_is_signed = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
    assign w_sa        = w_is_signed & a[WIDTH-1];
    assign w_sb        = w_is_signed & b[WIDTH-1];
    assign w_abs_a     = magnitude(a, w_sa);
    assign w_abs_b     = magnitude(b, w_sb);
    assign w_issue     = (r_state == S_IDLE) && valid && (w_is_mul || w_is_div) && !flush;
    assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

    // Restoring division step: shift in the next dividend bit, try to subtract the divisor.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_opb};

`ifdef MUL_ITER_EN
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opb} : '0);
`else
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

    // Magnitude results are sign-corrected only on the way into HI/LO.
    assign w_neg_q    = r_signed & (r_sa ^ r_sb);
    assign w_neg_r    = r_signed & r_sa;
    assign w_prod_fix = w_neg_q ? -{r_rem, r_quo} : {r_rem, r_quo};
    assign w_fix_hi   = r_is_mul ? w_prod_fix[2*WIDTH-1:WIDTH] : magnitude(r_rem, w_neg_r);
    assign w_fix_lo   = r_is_mul ? w_prod_fix[WIDTH-1:0]       : magnitude(r_quo, w_neg_q);

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    stall_o = 1'b1;
                    if (w_is_mul) begin
`ifdef MUL_ITER_EN
                        w_next = S_MUL;
`else
                        w_next = S_FIX;
`endif
                    end else if (b == '0) begin
                        w_next = S_FIX;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                stall_o = 1'b1;
                if (w_last_iter) w_next = S_FIX;
            end
            S_FIX: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next  = S_IDLE;
            stall_o = 1'b0;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + CW'(1);
            else                                       r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX && !flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if (r_state == S_IDLE && valid && !flush) begin
            if (alucontrol == MTHI_CONTROL) r_hi <= a;
            if (alucontrol == MTLO_CONTROL) r_lo <= a;
        end
    end

    // Working registers: r_rem/r_quo hold remainder/quotient or the high/low product halves.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_signed <= w_is_signed;
            r_is_mul <= w_is_mul;
            if (w_is_mul) begin
`ifdef MUL_ITER_EN
                r_rem <= '0;
                r_quo <= w_abs_b;
                r_opb <= w_abs_a;
`else
                {r_rem, r_quo} <= w_prod;
                r_opb          <= w_abs_b;
`endif
            end else if (b == '0) begin
                r_rem    <= a;
                r_quo    <= '1;
                r_opb    <= b;
                r_signed <= 1'b0;
            end else begin
                r_rem <= '0;
                r_quo <= w_abs_a;
                r_opb <= w_abs_b;
            end
        end else if (r_state == S_DIV) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
`ifdef MUL_ITER_EN
        else if (r_state == S_MUL) begin
            r_rem <= w_sum[WIDTH:1];
            r_quo <= {w_sum[0], r_quo[WIDTH-1:1]};
        end
`endif
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: table-driven directed vectors plus hand-written flush/reset/MTHI sequences.
module tb_hilo_muldiv;
    localparam int WIDTH = 32;
    localparam logic [4:0] C_NOP   = 5'b00000;
    localparam logic [4:0] C_DIV   = 5'b10000;
    localparam logic [4:0] C_DIVU  = 5'b10001;
    localparam logic [4:0] C_MULT  = 5'b10010;
    localparam logic [4:0] C_MULTU = 5'b10011;
    localparam logic [4:0] C_MTHI  = 5'b10100;
    localparam logic [4:0] C_MTLO  = 5'b10101;
    localparam logic [4:0] C_MFHI  = 5'b10110;
`ifdef MUL_ITER_EN
    localparam int MUL_LAT = WIDTH + 1;
`else
    localparam int MUL_LAT = 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;

    logic             clk = 1'b0;
    logic             resetn, valid, flush;
    logic [4:0]       alucontrol;
    logic [WIDTH-1:0] a, b;
    logic             stall_o, done_o;
    logic [WIDTH-1:0] hi_o, lo_o;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    hilo_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .alucontrol(alucontrol),
        .a(a), .b(b), .flush(flush), .stall_o(stall_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Issue one op, hold it valid while stalled (as a frozen pipeline would), count stall cycles.
    task automatic run_vec(input int idx);
        int  stall_cnt;
        int  done_cyc;
        bit  seen;
        vec_t v;
        v = vecs[idx];
        stall_cnt = 0;
        done_cyc  = -1;
        seen      = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; alucontrol = v.ctrl; a = v.a; b = v.b;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (done_o) begin
                done_cyc = cyc;
                seen     = 1'b1;
            end
            @(posedge clk); #1;
            if (cyc == 0) begin
                a = 32'hDEADBEEF;
                b = 32'h0;
            end
        end
        valid = 1'b0; alucontrol = C_NOP;
        @(negedge clk);
        chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_cnt), 32'(v.lat));
        chk($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.lat));
        chk($sformatf("v%0d_hi", idx), hi_o, v.hi);
        chk($sformatf("v%0d_lo", idx), lo_o, v.lo);
    endtask

    initial begin
        int busy_seen;

        vecs[0] = '{C_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT};
        vecs[1] = '{C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
        vecs[2] = '{C_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        vecs[3] = '{C_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1};
        vecs[4] = '{C_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        vecs[5] = '{C_DIVU,  32'h00000064, 32'h00000003, 32'h00000001, 32'h00000021, DIV_LAT};
        vecs[6] = '{C_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, MUL_LAT};

        resetn = 1'b0; valid = 1'b0; flush = 1'b0; alucontrol = C_NOP; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // MTHI/MTLO: write at the edge, no stall, no done
        @(posedge clk); #1;
        valid = 1'b1; alucontrol = C_MTHI; a = 32'h12345678;
        @(negedge clk);
        chk("mthi_stall", {31'b0, stall_o}, 32'h0);
        chk("mthi_done", {31'b0, done_o}, 32'h0);
        @(posedge clk); #1;
        alucontrol = C_MFHI; a = 32'h0BADF00D;
        @(negedge clk);
        chk("mfhi_hi", hi_o, 32'h12345678);
        chk("mfhi_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk); #1;
        alucontrol = C_MTLO; a = 32'hA5A5A5A5;
        @(posedge clk); #1;
        valid = 1'b0; alucontrol = C_NOP;
        @(negedge clk);
        chk("mtlo_lo", lo_o, 32'hA5A5A5A5);
        chk("mtlo_hi_kept", hi_o, 32'h12345678);

        // DIVU 100/3 flushed at cycle 10
        @(posedge clk); #1;
        valid = 1'b1; alucontrol = C_DIVU; a = 32'd100; b = 32'd3;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("flush_pre_stall", {31'b0, stall_o}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b1; valid = 1'b0; alucontrol = C_NOP;
        @(negedge clk);
        chk("flush_stall", {31'b0, stall_o}, 32'h0);
        chk("flush_done", {31'b0, done_o}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall_o || done_o) busy_seen++;
        end
        chk("flush_idle_after", 32'(busy_seen), 32'h0);
        chk("flush_hi_kept", hi_o, 32'h12345678);
        chk("flush_lo_kept", lo_o, 32'hA5A5A5A5);

        // Flush in FIX (divide by zero reaches FIX at cycle 1) suppresses the write
        @(posedge clk); #1;
        valid = 1'b1; alucontrol = C_DIVU; a = 32'd9; b = 32'd0;
        @(negedge clk);
        chk("fixflush_issue_stall", {31'b0, stall_o}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b1; valid = 1'b0; alucontrol = C_NOP;
        @(negedge clk);
        chk("fixflush_done", {31'b0, done_o}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fixflush_hi_kept", hi_o, 32'h12345678);
        chk("fixflush_lo_kept", lo_o, 32'hA5A5A5A5);

        // Unit returns to IDLE and accepts a fresh op
        run_vec(5);

        // Asynchronous reset in the middle of a DIV
        @(posedge clk); #1;
        valid = 1'b1; alucontrol = C_DIV; a = 32'hFFFFFFF9; b = 32'd2;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rstdiv_pre_stall", {31'b0, stall_o}, 32'h1);
        #2;
        resetn = 1'b0; valid = 1'b0; alucontrol = C_NOP;
        #1;
        chk("rstdiv_stall", {31'b0, stall_o}, 32'h0);
        chk("rstdiv_hi", hi_o, 32'h0);
        chk("rstdiv_lo", lo_o, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall_o || done_o) busy_seen++;
        end
        chk("rstdiv_no_done", 32'(busy_seen), 32'h0);
        chk("rstdiv_lo_after", lo_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
